// File: rtl/seven_seg_display_driver.sv
// seven_seg_display_driver
//   Drives a 4-digit common-anode seven-segment display from a 16-bit value.
//   The value is sampled periodically, optionally converted to decimal with a
//   sequential double-dabble engine, latched into a display register and then
//   scanned out one digit at a time.
//
// Ports:
//   clk           system clock, all logic on the rising edge
//   rst           synchronous active-high reset
//   display_data  16-bit value to display
//   decimal_point dp mask, bit k lights the dp of digit k (digit 0 rightmost)
//   bcd_mode      1 = decimal display, 0 = hex display
//   an            digit enables, active-low one-hot, an[0] = rightmost digit
//   seg           segments {g,f,e,d,c,b,a}, active-low
//   dp            decimal point, active-low
//   update_pulse  one-cycle pulse when the display register takes a new value
module seven_seg_display_driver #(
  parameter int REFRESH_COUNT       = 100_000,
  parameter bit BLANK_LEADING_ZEROS = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] display_data,
  input  logic [3:0]  decimal_point,
  input  logic        bcd_mode,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        update_pulse
);

  localparam int CW = (REFRESH_COUNT > 2) ? $clog2(REFRESH_COUNT) : 1;
  localparam logic [CW-1:0] REFRESH_LAST = CW'(REFRESH_COUNT - 1);

  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

  state_t      state, state_next;
  logic [15:0] data_cap;
  logic [3:0]  dp_cap;
  logic        bcd_cap;
  logic [19:0] bcd_acc;
  logic [19:0] bcd_adj;
  logic [4:0]  shift_cnt;

  logic [15:0] disp_digits;
  logic        disp_bcd;
  logic        disp_ovf;
  logic [3:0]  disp_dp;

  logic [CW-1:0] refresh_cnt;
  logic [1:0]    digit_idx;
  logic [3:0]    cur_nibble;
  logic [3:0]    blank_vec;
  logic [6:0]    seg_next;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    case (v)
      4'h0: hex_to_seg = 7'b1000000;
      4'h1: hex_to_seg = 7'b1111001;
      4'h2: hex_to_seg = 7'b0100100;
      4'h3: hex_to_seg = 7'b0110000;
      4'h4: hex_to_seg = 7'b0011001;
      4'h5: hex_to_seg = 7'b0010010;
      4'h6: hex_to_seg = 7'b0000010;
      4'h7: hex_to_seg = 7'b1111000;
      4'h8: hex_to_seg = 7'b0000000;
      4'h9: hex_to_seg = 7'b0010000;
      4'hA: hex_to_seg = 7'b0001000;
      4'hB: hex_to_seg = 7'b0000011;
      4'hC: hex_to_seg = 7'b1000110;
      4'hD: hex_to_seg = 7'b0100001;
      4'hE: hex_to_seg = 7'b0000110;
      default: hex_to_seg = 7'b0001110;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  state_next = SHIFT;
      SHIFT: if (shift_cnt == 5'd15) state_next = LOAD;
      LOAD:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Double-dabble correction: any BCD digit of 5 or more would overflow
  // past 9 when doubled, so pre-add 3 before the shift.
  always_comb begin
    bcd_adj = bcd_acc;
    for (int i = 0; i < 5; i++) begin
      if (bcd_acc[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_acc[4*i +: 4] + 4'd3;
    end
  end

  // data_cap stays intact through the conversion so hex mode can load it
  // directly; the shift engine picks its bits MSB-first by index.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_cap     <= '0;
      dp_cap       <= '0;
      bcd_cap      <= 1'b0;
      bcd_acc      <= '0;
      shift_cnt    <= '0;
      disp_digits  <= '0;
      disp_bcd     <= 1'b0;
      disp_ovf     <= 1'b0;
      disp_dp      <= '0;
      update_pulse <= 1'b0;
    end else begin
      update_pulse <= 1'b0;
      case (state)
        IDLE: begin
          data_cap  <= display_data;
          dp_cap    <= decimal_point;
          bcd_cap   <= bcd_mode;
          bcd_acc   <= '0;
          shift_cnt <= '0;
        end
        SHIFT: begin
          bcd_acc   <= {bcd_adj[18:0], data_cap[4'd15 - shift_cnt[3:0]]};
          shift_cnt <= shift_cnt + 5'd1;
        end
        LOAD: begin
          update_pulse <= 1'b1;
          disp_dp      <= dp_cap;
          disp_bcd     <= bcd_cap;
          if (bcd_cap) begin
            disp_digits <= bcd_acc[15:0];
            disp_ovf    <= |bcd_acc[19:16];
          end else begin
            disp_digits <= data_cap;
            disp_ovf    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      refresh_cnt <= '0;
      digit_idx   <= '0;
    end else if (refresh_cnt == REFRESH_LAST) begin
      refresh_cnt <= '0;
      digit_idx   <= digit_idx + 2'd1;
    end else begin
      refresh_cnt <= refresh_cnt + CW'(1);
    end
  end

  // A digit is a leading zero only if it and every digit to its left are
  // zero and carry no lit decimal point; walk from the leftmost digit down.
  always_comb begin : blank_calc
    logic lz;
    blank_vec = '0;
    lz = BLANK_LEADING_ZEROS && disp_bcd && !disp_ovf;
    for (int k = 3; k >= 1; k--) begin
      lz = lz && (disp_digits[4*k +: 4] == 4'd0) && !disp_dp[k];
      blank_vec[k] = lz;
    end
  end

  always_comb begin
    cur_nibble = disp_digits[{digit_idx, 2'b00} +: 4];
    if (disp_ovf)                  seg_next = SEG_DASH;
    else if (blank_vec[digit_idx]) seg_next = SEG_BLANK;
    else                           seg_next = hex_to_seg(cur_nibble);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      an  <= 4'b1111;
      seg <= SEG_BLANK;
      dp  <= 1'b1;
    end else begin
      an  <= ~(4'b0001 << digit_idx);
      seg <= seg_next;
      dp  <= ~disp_dp[digit_idx];
    end
  end

endmodule

// File: tb/tb_seven_seg_display_driver.sv
// tb_seven_seg_display_driver
//   Scoreboard bench: every driven input set pushes its expected display
//   image; each update_pulse pops the next image and the scan outputs are
//   compared against it every cycle until the following update.
module tb_seven_seg_display_driver;

  logic        clk;
  logic        rst;
  logic [15:0] display_data;
  logic [3:0]  decimal_point;
  logic        bcd_mode;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        update_pulse;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct packed {
    logic [6:0] s3;
    logic [6:0] s2;
    logic [6:0] s1;
    logic [6:0] s0;
    logic [3:0] dpm;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;

  localparam logic [6:0] SEG_TAB [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  seven_seg_display_driver #(
    .REFRESH_COUNT(4),
    .BLANK_LEADING_ZEROS(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .display_data(display_data),
    .decimal_point(decimal_point),
    .bcd_mode(bcd_mode),
    .an(an),
    .seg(seg),
    .dp(dp),
    .update_pulse(update_pulse)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  function automatic exp_t model(input logic [15:0] d, input logic [3:0] m, input logic b);
    exp_t       e;
    int         p10[4] = '{1, 10, 100, 1000};
    int         v;
    logic [3:0] dig[4];
    logic [6:0] s[4];
    logic       ovf;
    logic       lz;
    v   = int'(d);
    ovf = b && (v > 9999);
    for (int k = 0; k < 4; k++) begin
      dig[k] = b ? 4'((v / p10[k]) % 10) : d[4*k +: 4];
      s[k]   = ovf ? 7'b0111111 : SEG_TAB[dig[k]];
    end
    lz = b && !ovf;
    for (int k = 3; k >= 1; k--) begin
      lz = lz && (dig[k] == 4'd0) && !m[k];
      if (lz) s[k] = 7'b1111111;
    end
    e.s3 = s[3]; e.s2 = s[2]; e.s1 = s[1]; e.s0 = s[0];
    e.dpm = m;
    return e;
  endfunction

  function automatic logic [6:0] seg_of(input exp_t e, input logic [1:0] idx);
    case (idx)
      2'd0: seg_of = e.s0;
      2'd1: seg_of = e.s1;
      2'd2: seg_of = e.s2;
      default: seg_of = e.s3;
    endcase
  endfunction

  // Scan monitor: models the digit index independently and compares the
  // registered outputs once per cycle on the falling edge.
  bit         rst_q = 1'b1;
  bit         was_reset;
  logic [1:0] m_idx;
  int         m_cnt;
  logic [3:0] exp_an;
  logic       exp_dp;

  always @(negedge clk) begin
    was_reset = rst_q;
    rst_q = rst;
    if (was_reset) begin
      checkOutput("reset_an", an, 4'b1111);
      checkOutput("reset_seg", seg, 7'b1111111);
      checkOutput("reset_dp", dp, 1'b1);
      checkOutput("reset_pulse", update_pulse, 1'b0);
      m_idx = 2'd0;
      m_cnt = 0;
      cur = model(16'd0, 4'd0, 1'b0);
    end else begin
      exp_an = ~(4'b0001 << m_idx);
      exp_dp = ~cur.dpm[m_idx];
      checkOutput("an", an, exp_an);
      checkOutput("seg", seg, seg_of(cur, m_idx));
      checkOutput("dp", dp, exp_dp);
      if (m_cnt == 3) begin
        m_cnt = 0;
        m_idx = m_idx + 2'd1;
      end else begin
        m_cnt++;
      end
      if (update_pulse && exp_q.size() > 0) cur = exp_q.pop_front();
    end
  end

  task automatic applyStimulus(input logic [15:0] d, input logic [3:0] m, input logic b);
    display_data  = d;
    decimal_point = m;
    bcd_mode      = b;
    exp_q.push_back(model(d, m, b));
  endtask

  // Returns just after the edge that raises update_pulse; the number of
  // edges it took is itself a comparison.
  task automatic waitPulse(input int expected_cycles);
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (update_pulse) seen = 1'b1;
    end
    checkOutput("pulse_gap", n, expected_cycles);
  endtask

  initial begin
    rst           = 1'b1;
    display_data  = 16'd0;
    decimal_point = 4'd0;
    bcd_mode      = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.push_back(model(16'd0, 4'd0, 1'b0));
    waitPulse(18);

    applyStimulus(16'd3300, 4'b1000, 1'b1);   waitPulse(18);
    applyStimulus(16'd42, 4'b0000, 1'b1);     waitPulse(18);
    applyStimulus(16'd42, 4'b0100, 1'b1);     waitPulse(18);
    applyStimulus(16'd12345, 4'b0000, 1'b1);  waitPulse(18);
    applyStimulus(16'hBEEF, 4'b0000, 1'b0);   waitPulse(18);

    // Inputs changed mid-conversion are held off until the next capture.
    applyStimulus(16'd3300, 4'b1000, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    applyStimulus(16'd1234, 4'b0100, 1'b1);
    waitPulse(13);
    waitPulse(18);

    // Reset on the 10th shift cycle aborts that conversion entirely.
    applyStimulus(16'd9876, 4'b0011, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    exp_q.push_back(model(16'd9876, 4'b0011, 1'b1));
    waitPulse(18);

    applyStimulus(16'd7, 4'b0000, 1'b1);      waitPulse(18);
    waitPulse(18);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
